// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control/status bundle for the programmable clock divider
interface clk_div_prog_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             div_wr;
    logic [WIDTH-1:0] div_in;
    logic             div_pend;
    logic [WIDTH-1:0] div_cur;
    logic             new_clk;
    logic             tick;

    modport master (
        output en, div_wr, div_in,
        input  div_pend, div_cur, new_clk, tick
    );

    modport slave (
        input  en, div_wr, div_in,
        output div_pend, div_cur, new_clk, tick
    );
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable integer / fractional clock divider with shadowed divisor updates
module clk_div_prog #(
    parameter int IN_FREQ  = 50000000,
    parameter int OUT_FREQ = 9600,
    parameter int WIDTH    = 32,
    parameter int MODE     = 0
) (
    input logic           clk,
    input logic           rst,
    clk_div_prog_if.slave bus
);
    localparam logic [63:0] RST_WIDE = (MODE == 0) ? 64'(IN_FREQ / OUT_FREQ)
        : (((64'(OUT_FREQ) << WIDTH) + 64'(IN_FREQ / 2)) / 64'(IN_FREQ));
    localparam logic [WIDTH-1:0] RST_DIV = RST_WIDE[WIDTH-1:0];

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_div_cur;
    logic             r_pend;
    logic             r_tick;
    logic             r_new_clk;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH:0]   w_sum;
    logic             w_wrap;
    logic             w_load;
    logic             w_clk_nxt;

    // Next count/phase, wrap detection and divisor load decision; r_cnt doubles as the phase accumulator in MODE 1
    always_comb begin
        w_d       = (r_div_cur < WIDTH'(2)) ? WIDTH'(2) : r_div_cur;
        w_sum     = {1'b0, r_cnt} + {1'b0, r_div_cur};
        w_wrap    = (MODE == 0) ? (r_cnt >= w_d - WIDTH'(1)) : w_sum[WIDTH];
        w_cnt_nxt = (MODE == 0) ? (w_wrap ? '0 : r_cnt + WIDTH'(1)) : w_sum[WIDTH-1:0];
        w_clk_nxt = (MODE == 0) ? (w_wrap | (r_new_clk & (w_cnt_nxt != (w_d >> 1))))
                                : w_sum[WIDTH-1];
        w_load    = r_pend & (~bus.en | w_wrap);
    end

    // Counter, output flops and shadow divisor; a load only happens at a period boundary while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_div_cur <= RST_DIV;
            r_pend    <= 1'b0;
            r_tick    <= 1'b0;
            r_new_clk <= 1'b0;
        end else begin
            r_tick <= bus.en & w_wrap;
            if (bus.en) begin
                r_cnt     <= w_cnt_nxt;
                r_new_clk <= w_clk_nxt;
            end
            if (w_load)
                r_div_cur <= r_shadow;
            if (bus.div_wr)
                r_shadow <= bus.div_in;
            r_pend <= bus.div_wr | (r_pend & ~w_load);
        end
    end

    assign bus.div_pend = r_pend;
    assign bus.div_cur  = r_div_cur;
    assign bus.new_clk  = r_new_clk;
    assign bus.tick     = r_tick;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed bench for integer and fractional divider instances against a period-level model
module tb_clk_div_prog;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clk_div_prog_if #(.WIDTH(16)) ia ();
    clk_div_prog_if #(.WIDTH(8))  ib ();

    clk_div_prog #(.IN_FREQ(100), .OUT_FREQ(10), .WIDTH(16), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .bus(ia)
    );
    clk_div_prog #(.IN_FREQ(100), .OUT_FREQ(10), .WIDTH(8), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ib)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: A tracks position inside the current period, B tracks phase modulo 256
    int ma_cur, ma_sh, ma_pos, a_d;
    bit ma_pend, ma_started, ma_tick, a_wrap, a_ld;
    int mb_cur, mb_sh, mb_phase;
    bit mb_pend, mb_tick, b_wrap, b_ld;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma_cur = 100 / 10; ma_sh = 0; ma_pos = 0; ma_pend = 0; ma_started = 0; ma_tick = 0;
            mb_cur = (10 * 256 + 50) / 100; mb_sh = 0; mb_phase = 0; mb_pend = 0; mb_tick = 0;
        end else begin
            a_d = (ma_cur < 2) ? 2 : ma_cur;
            a_wrap = ia.en && (ma_pos == a_d - 1);
            ma_tick = a_wrap;
            if (ia.en) begin
                if (a_wrap) begin
                    ma_pos = 0;
                    ma_started = 1;
                end else
                    ma_pos++;
            end
            a_ld = ma_pend && (!ia.en || a_wrap);
            if (a_ld) ma_cur = ma_sh;
            if (ia.div_wr) ma_sh = int'(ia.div_in);
            ma_pend = ia.div_wr || (ma_pend && !a_ld);
            b_wrap = ib.en && (mb_phase + mb_cur >= 256);
            mb_tick = b_wrap;
            if (ib.en) mb_phase = (mb_phase + mb_cur) % 256;
            b_ld = mb_pend && (!ib.en || b_wrap);
            if (b_ld) mb_cur = mb_sh;
            if (ib.div_wr) mb_sh = int'(ib.div_in);
            mb_pend = ib.div_wr || (mb_pend && !b_ld);
        end
    end

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (!rst) begin
            check("a_tick", ia.tick, ma_tick);
            check("a_new_clk", ia.new_clk,
                  (ma_started && ma_pos < (((ma_cur < 2) ? 2 : ma_cur) >> 1)) ? 1 : 0);
            check("a_div_pend", ia.div_pend, ma_pend);
            check("a_div_cur", ia.div_cur, ma_cur);
            check("b_tick", ib.tick, mb_tick);
            check("b_new_clk", ib.new_clk, (mb_phase >= 128) ? 1 : 0);
            check("b_div_pend", ib.div_pend, mb_pend);
            check("b_div_cur", ib.div_cur, mb_cur);
        end
    end

    task automatic wait_tick(input bit sel, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? ib.tick : ia.tick) && n < 300);
        if (!(sel ? ib.tick : ia.tick)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_tick%0d: no tick within %0d cycles", sel, n);
        end
    endtask

    task automatic count_high(input bit sel, input int len, output int s);
        s = int'(sel ? ib.new_clk : ia.new_clk);
        repeat (len - 1) begin
            @(negedge clk);
            s += int'(sel ? ib.new_clk : ia.new_clk);
        end
    endtask

    task automatic write_a(input int v);
        ia.div_wr = 1'b1;
        ia.div_in = 16'(v);
        @(negedge clk);
        ia.div_wr = 1'b0;
    endtask

    task automatic write_b(input int v);
        ib.div_wr = 1'b1;
        ib.div_in = 8'(v);
        @(negedge clk);
        ib.div_wr = 1'b0;
    endtask

    initial begin
        int n, s, t, ch;
        logic nc;
        ia.en = 1'b0; ia.div_wr = 1'b0; ia.div_in = '0;
        ib.en = 1'b0; ib.div_wr = 1'b0; ib.div_in = '0;
        repeat (2) @(negedge clk);
        check("rst_a_div_cur", ia.div_cur, 10);
        check("rst_b_div_cur", ib.div_cur, 26);
        check("rst_a_tick", ia.tick, 0);
        check("rst_a_new_clk", ia.new_clk, 0);
        check("rst_a_div_pend", ia.div_pend, 0);
        ia.en = 1'b1;
        ib.en = 1'b1;
        rst = 1'b0;
        wait_tick(0, n); check("first_tick_a", n, 10);
        wait_tick(0, n); check("period10", n, 10);
        count_high(0, 10, s); check("high10", s, 5);
        wait_tick(0, n);
        repeat (3) @(negedge clk);
        write_a(7);
        check("pend_after_wr7", ia.div_pend, 1);
        wait_tick(0, n); check("old_period_kept", n, 6);
        check("pend_cleared", ia.div_pend, 0);
        wait_tick(0, n); check("period7", n, 7);
        count_high(0, 7, s); check("high7", s, 3);
        wait_tick(0, n);
        write_a(0);
        wait_tick(0, n);
        wait_tick(0, n); check("period_d0", n, 2);
        write_a(1);
        wait_tick(0, n);
        wait_tick(0, n); check("period_d1", n, 2);
        write_b(64);
        wait_tick(1, n);
        wait_tick(1, n); check("b_period64", n, 4);
        count_high(1, 4, s); check("b_high64", s, 2);
        write_b(0);
        wait_tick(1, n);
        check("b_div_cur0", ib.div_cur, 0);
        t = 0;
        repeat (20) begin
            @(negedge clk);
            t += int'(ib.tick);
        end
        check("b_ticks_stopped", t, 0);
        write_a(10);
        wait_tick(0, n);
        wait_tick(0, n);
        wait_tick(0, n); check("period_back10", n, 10);
        repeat (6) @(negedge clk);
        ia.en = 1'b0;
        nc = ia.new_clk;
        t = 0;
        ch = 0;
        repeat (20) begin
            @(negedge clk);
            t += int'(ia.tick);
            ch += int'(ia.new_clk != nc);
        end
        check("hold_ticks", t, 0);
        check("hold_new_clk_changes", ch, 0);
        ia.en = 1'b1;
        wait_tick(0, n); check("resume_tick", n, 4);
        repeat (3) @(negedge clk);
        write_a(5);
        check("pend_before_rst", ia.div_pend, 1);
        check("high_before_rst", ia.new_clk, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_new_clk", ia.new_clk, 0);
        check("rst_mid_pend", ia.div_pend, 0);
        check("rst_mid_div_cur", ia.div_cur, 10);
        check("rst_mid_b_div_cur", ib.div_cur, 26);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_tick(0, n); check("tick_after_rst", n, 10);
        wait_tick(0, n); check("period_after_rst", n, 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
